uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Purpose: shared FSM encoding and width helper for the uart_tx arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3
  } state_t;

  // Ceiling log2 for sizing index and counter fields (returns 0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Purpose: rotate-priority encoder; first set req bit at ptr, ptr+1, ... (mod N).
// Latency: combinational.
// Backpressure: none; the result is recomputed from req/ptr every cycle.
//
// Ports:
//   req        N  request vector
//   ptr        W  starting index of the scan (must be < N)
//   grant_idx  W  index of the winning request (0 when none)
//   any        1  at least one request is set
module uart_tx_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant_idx,
  output logic         any
);

  // (p + off) mod N, valid for p < N and 0 <= off < N.
  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= N) begin
      s = s - N;
    end
    return W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[wrap_add(ptr, i)]) begin
        grant_idx = wrap_add(ptr, i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin owner of one uart_tx; each grant sends a burst of up to MAX_BURST bytes.
// Latency: ack 1 cycle after req in idle; o_Tx_Start 1 cycle after ack.
// Backpressure: waits on i_Tx_Done then !i_Tx_Active; watchdog aborts a stalled transfer.
//
// Ports:
//   i_Clock, i_reset         clock, asynchronous active-high reset
//   i_req [N_REQ]            per-requester byte available
//   i_data [N_REQ*Bits]      requester k byte at [k*Bits +: Bits]
//   o_ack [N_REQ]            one-hot pulse: byte latched, present next or drop req
//   o_Tx_Start, o_Tx_Byte    to uart_tx; byte held from start until done
//   i_Tx_Done, i_Tx_Active   from uart_tx
//   o_busy, o_owner, o_err   status; o_err pulses on watchdog abort
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int Bits        = 8,
  parameter  int MAX_BURST   = 16,
  parameter  int TIMEOUT_CYC = 1048576,
  localparam int OW          = clog2(N_REQ)
) (
  input  logic                  i_Clock,
  input  logic                  i_reset,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ*Bits-1:0] i_data,
  output logic [N_REQ-1:0]      o_ack,
  output logic                  o_Tx_Start,
  output logic [Bits-1:0]       o_Tx_Byte,
  input  logic                  i_Tx_Done,
  input  logic                  i_Tx_Active,
  output logic                  o_busy,
  output logic [OW-1:0]         o_owner,
  output logic                  o_err
);

  localparam int BW = clog2(MAX_BURST + 1);
  localparam int WW = clog2(TIMEOUT_CYC);

  state_t           state_q, state_d;
  logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic [WW-1:0]    wdog_q, wdog_d;
  logic [N_REQ-1:0] ack_d;
  logic             start_d, err_d, busy_d;
  logic [Bits-1:0]  byte_d;
  logic [OW-1:0]    owner_d;

  logic [OW-1:0]    pick_idx;
  logic             pick_any;
  logic [OW-1:0]    next_ptr;

  uart_tx_arbiter_rr_pick #(
    .N (N_REQ),
    .W (OW)
  ) u_pick (
    .req       (i_req),
    .ptr       (rr_ptr_q),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // Rotation point after the current owner gives up the transmitter.
  assign next_ptr = (o_owner == OW'(N_REQ - 1)) ? '0 : o_owner + OW'(1);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    wdog_d   = wdog_q;
    ack_d    = '0;
    start_d  = 1'b0;
    err_d    = 1'b0;
    byte_d   = o_Tx_Byte;
    owner_d  = o_owner;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          byte_d          = i_data[pick_idx*Bits +: Bits];
          owner_d         = pick_idx;
          ack_d[pick_idx] = 1'b1;
          burst_d         = BW'(1);
          state_d         = S_START;
        end
      end
      S_START: begin
        start_d = 1'b1;
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_Tx_Done) begin
          state_d = S_DRAIN;
        end else if (wdog_q == WW'(TIMEOUT_CYC - 1)) begin
          err_d    = 1'b1;
          rr_ptr_d = next_ptr;
          state_d  = S_IDLE;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      S_DRAIN: begin
        // uart_tx only accepts a new start once it has dropped Active.
        if (!i_Tx_Active) begin
          if (i_req[o_owner] && (burst_q < BW'(MAX_BURST))) begin
            byte_d         = i_data[o_owner*Bits +: Bits];
            ack_d[o_owner] = 1'b1;
            burst_d        = burst_q + BW'(1);
            state_d        = S_START;
          end else begin
            rr_ptr_d = next_ptr;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_Clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      burst_q    <= '0;
      wdog_q     <= '0;
      o_ack      <= '0;
      o_Tx_Start <= 1'b0;
      o_Tx_Byte  <= '0;
      o_busy     <= 1'b0;
      o_owner    <= '0;
      o_err      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      burst_q    <= burst_d;
      wdog_q     <= wdog_d;
      o_ack      <= ack_d;
      o_Tx_Start <= start_d;
      o_Tx_Byte  <= byte_d;
      o_busy     <= busy_d;
      o_owner    <= owner_d;
      o_err      <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: directed self-checking bench for uart_tx_arbiter with a behavioural uart_tx.
// Latency: n/a.
// Backpressure: the uart_tx model holds Active for a 10-bit frame and can be made to hang.
module tb_uart_tx_arbiter;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        busy;
  logic [1:0]  owner;
  logic        err;

  logic        m_active;
  logic        m_done;
  int          m_cnt;
  logic [7:0]  m_byte;
  logic        hang;
  int          unstable = 0;
  logic [7:0]  sent_q[$];

  logic [7:0]  rq_mem[4][32];
  int          rq_head[4];
  int          rq_len[4];
  int          ack_log[$];
  int          own_log[$];

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_arbiter #(
    .N_REQ       (4),
    .Bits        (8),
    .MAX_BURST   (16),
    .TIMEOUT_CYC (64)
  ) dut (
    .i_Clock     (clk),
    .i_reset     (rst),
    .i_req       (req),
    .i_data      (data),
    .o_ack       (ack),
    .o_Tx_Start  (tx_start),
    .o_Tx_Byte   (tx_byte),
    .i_Tx_Done   (m_done),
    .i_Tx_Active (m_active),
    .o_busy      (busy),
    .o_owner     (owner),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  // uart_tx model: samples the byte at the first baud tick, Done/!Active at frame end.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_cnt    <= 0;
      m_byte   <= 8'h00;
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (tx_start) begin
          m_active <= 1'b1;
          m_cnt    <= 0;
          m_byte   <= tx_byte;
        end
      end else begin
        m_cnt <= m_cnt + 1;
        if (tx_byte !== m_byte) unstable <= unstable + 1;
        if (m_cnt == CPB - 1) sent_q.push_back(tx_byte);
        if (m_cnt == FRAME - 1 && !hang) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic refresh_inputs();
    for (int k = 0; k < 4; k++) begin
      req[k] = (rq_head[k] < rq_len[k]);
      data[k*8 +: 8] = req[k] ? rq_mem[k][rq_head[k]] : 8'h00;
    end
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < 4; k++) begin
      rq_head[k] = 0;
      rq_len[k]  = 0;
    end
    ack_log.delete();
    own_log.delete();
    sent_q.delete();
  endtask

  // Requesters consume their byte on ack; returns once everything is drained.
  task automatic serve(input string name, input int max_cyc);
    int c;
    bit fin;
    c = 0;
    fin = 1'b0;
    while (!fin && c < max_cyc) begin
      tick();
      c++;
      if (ack != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (ack[k]) begin
            ack_log.push_back(k);
            own_log.push_back(int'(owner));
            rq_head[k]++;
          end
        end
        refresh_inputs();
      end
      if (req == 4'b0000 && !busy && !m_active) fin = 1'b1;
    end
    n_cmp++;
    if (!fin) begin
      n_bad++;
      $display("FAIL %s_timeout: busy=%0b req=%b after %0d cycles, required idle", name, busy, req, c);
    end
  endtask

  task automatic wait_start(input string name);
    int w;
    w = 0;
    while (tx_start !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    n_cmp++;
    if (tx_start !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_start: o_Tx_Start=%b after %0d cycles, required 1", name, tx_start, w);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL rst_ack: got %b, required 0000", ack); end
    n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL rst_start: got %b, required 0", tx_start); end
    n_cmp++; if (tx_byte !== 8'h00) begin n_bad++; $display("FAIL rst_byte: got %h, required 00", tx_byte); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL rst_owner: got %0d, required 0", owner); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b, required 0", err); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_single();
    clear_reqs();
    rq_mem[0][0] = 8'h55; rq_len[0] = 1;
    refresh_inputs();
    tick();
    n_cmp++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL single_ack: got %b, required 0001", ack); end
    n_cmp++; if (tx_byte !== 8'h55) begin n_bad++; $display("FAIL single_byte: got %h, required 55", tx_byte); end
    n_cmp++; if (busy !== 1'b1 || owner !== 2'd0) begin n_bad++; $display("FAIL single_owner: busy=%b owner=%0d, required 1/0", busy, owner); end
    n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL single_early_start: got %b, required 0", tx_start); end
    rq_head[0]++;
    refresh_inputs();
    tick();
    n_cmp++; if (tx_start !== 1'b1 || ack !== 4'b0000) begin n_bad++; $display("FAIL single_start: start=%b ack=%b, required 1/0000", tx_start, ack); end
    tick();
    n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL single_start_pulse: got %b, required 0", tx_start); end
    serve("single", 300);
    n_cmp++;
    if (sent_q.size() != 1 || sent_q[0] !== 8'h55) begin
      n_bad++; $display("FAIL single_frame: %0d bytes first=%h, required 1 byte 55", sent_q.size(), sent_q[0]);
    end
  endtask

  // rr_ptr is 1 here: req1 wins before req3.
  task automatic test_pair();
    clear_reqs();
    rq_mem[1][0] = 8'hB3; rq_len[1] = 1;
    rq_mem[3][0] = 8'hA1; rq_len[3] = 1;
    refresh_inputs();
    serve("pair", 400);
    n_cmp++;
    if (ack_log.size() != 2 || ack_log[0] != 1 || ack_log[1] != 3) begin
      n_bad++; $display("FAIL pair_ack_order: %0d acks first=%0d, required 1 then 3", ack_log.size(), ack_log[0]);
    end
    n_cmp++;
    if (own_log.size() != 2 || own_log[0] != 1 || own_log[1] != 3) begin
      n_bad++; $display("FAIL pair_owner: %0d entries first=%0d, required 1 then 3", own_log.size(), own_log[0]);
    end
    n_cmp++;
    if (sent_q.size() != 2 || sent_q[0] !== 8'hB3 || sent_q[1] !== 8'hA1) begin
      n_bad++; $display("FAIL pair_bytes: %0d bytes first=%h, required B3 then A1", sent_q.size(), sent_q[0]);
    end
  endtask

  // rr_ptr wrapped to 0: 16 bytes from req0, one from req2, then req0 resumes.
  task automatic test_burst();
    logic [7:0] exp_b[$];
    int         exp_a[$];
    int         bad_i;
    clear_reqs();
    for (int i = 0; i < 20; i++) rq_mem[0][i] = 8'(i);
    rq_len[0] = 20;
    rq_mem[2][0] = 8'hC2; rq_len[2] = 1;
    for (int i = 0; i < 16; i++) begin exp_b.push_back(8'(i)); exp_a.push_back(0); end
    exp_b.push_back(8'hC2); exp_a.push_back(2);
    for (int i = 16; i < 20; i++) begin exp_b.push_back(8'(i)); exp_a.push_back(0); end
    refresh_inputs();
    serve("burst", 3000);
    bad_i = -1;
    if (sent_q.size() != exp_b.size()) bad_i = sent_q.size();
    else for (int i = 0; i < exp_b.size(); i++) if (bad_i < 0 && sent_q[i] !== exp_b[i]) bad_i = i;
    n_cmp++;
    if (bad_i >= 0) begin
      n_bad++; $display("FAIL burst_bytes: %0d bytes, first bad index %0d, required 00..0F,C2,10..13", sent_q.size(), bad_i);
    end
    bad_i = -1;
    if (ack_log.size() != exp_a.size()) bad_i = ack_log.size();
    else for (int i = 0; i < exp_a.size(); i++) if (bad_i < 0 && ack_log[i] != exp_a[i]) bad_i = i;
    n_cmp++;
    if (bad_i >= 0) begin
      n_bad++; $display("FAIL burst_acks: %0d acks, first bad index %0d, required 16x0, 2, 4x0", ack_log.size(), bad_i);
    end
  endtask

  // rr_ptr is 1; req2 presents a second byte then drops req while in S_WAIT.
  task automatic test_drop();
    clear_reqs();
    unstable = 0;
    rq_mem[2][0] = 8'h3C; rq_mem[2][1] = 8'h77; rq_len[2] = 2;
    refresh_inputs();
    tick();
    n_cmp++; if (ack !== 4'b0100) begin n_bad++; $display("FAIL drop_ack: got %b, required 0100", ack); end
    rq_head[2]++;
    refresh_inputs();
    wait_start("drop");
    tick();
    rq_len[2] = rq_head[2];
    refresh_inputs();
    data[23:16] = 8'hEE;
    serve("drop", 300);
    n_cmp++; if (ack_log.size() != 0) begin n_bad++; $display("FAIL drop_extra_ack: got %0d acks, required 0", ack_log.size()); end
    n_cmp++;
    if (sent_q.size() != 1 || sent_q[0] !== 8'h3C) begin
      n_bad++; $display("FAIL drop_frame: %0d bytes first=%h, required 1 byte 3C", sent_q.size(), sent_q[0]);
    end
    n_cmp++; if (tx_byte !== 8'h3C) begin n_bad++; $display("FAIL drop_byte_hold: got %h, required 3C", tx_byte); end
    n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL drop_byte_stable: %0d changes during frame, required 0", unstable); end
  endtask

  // rr_ptr is 3; req1 wins and the transmitter never finishes.
  task automatic test_watchdog();
    int n;
    clear_reqs();
    hang = 1'b1;
    rq_mem[1][0] = 8'h99; rq_len[1] = 1;
    refresh_inputs();
    tick();
    n_cmp++; if (ack !== 4'b0010) begin n_bad++; $display("FAIL wdog_ack: got %b, required 0010", ack); end
    rq_head[1]++;
    refresh_inputs();
    wait_start("wdog");
    n = 0;
    while (err !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    n_cmp++; if (n != 64) begin n_bad++; $display("FAIL wdog_delay: o_err after %0d cycles, required 64", n); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wdog_idle: busy=%b, required 0", busy); end
    tick();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wdog_pulse: o_err=%b one cycle later, required 0", err); end
  endtask

  // rr_ptr is 2 after the abort; reset mid-S_WAIT then serve again from rr_ptr 0.
  task automatic test_reset_mid();
    clear_reqs();
    rq_mem[0][0] = 8'h10; rq_len[0] = 1;
    rq_mem[2][0] = 8'h20; rq_len[2] = 1;
    refresh_inputs();
    tick();
    n_cmp++;
    if (ack !== 4'b0100 || tx_byte !== 8'h20) begin
      n_bad++; $display("FAIL ptr_after_abort: ack=%b byte=%h, required 0100/20", ack, tx_byte);
    end
    wait_start("mid");
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({ack, tx_start, tx_byte, owner, err} !== 16'h0000) begin
      n_bad++; $display("FAIL mid_reset_outs: ack=%b start=%b byte=%h owner=%0d err=%b, required all 0", ack, tx_start, tx_byte, owner, err);
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy: got %b, required 0", busy); end
    @(negedge clk);
    @(negedge clk);
    hang = 1'b0;
    rst = 1'b0;
    sent_q.delete();
    serve("after_reset", 400);
    n_cmp++;
    if (ack_log.size() != 2 || ack_log[0] != 0 || ack_log[1] != 2) begin
      n_bad++; $display("FAIL after_reset_order: %0d acks first=%0d, required 0 then 2", ack_log.size(), ack_log[0]);
    end
    n_cmp++;
    if (sent_q.size() != 2 || sent_q[0] !== 8'h10 || sent_q[1] !== 8'h20) begin
      n_bad++; $display("FAIL after_reset_bytes: %0d bytes first=%h, required 10 then 20", sent_q.size(), sent_q[0]);
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    data = 32'h0;
    hang = 1'b0;
    clear_reqs();
    test_reset();
    test_single();
    test_pair();
    test_burst();
    test_drop();
    test_watchdog();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
